// File: rtl/alu_cmd_driver_if.sv
// Bundle of the command, ALU-side and result channels of alu_cmd_driver.
// The master modport is the driver; the slave modport is its environment.
interface alu_cmd_driver_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [3:0]       cmd_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic             alu_enable;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_err;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    output cmd_ready,
    output alu_a, alu_b, alu_op, alu_enable,
    input  alu_out, alu_zero,
    output res_valid, res_data, res_zero, res_err,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op, alu_enable,
    output alu_out, alu_zero,
    input  res_valid, res_data, res_zero, res_err,
    output res_ready
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Initiator for a clocked ALU: accepts one command, issues it for one cycle,
// waits LATENCY edges, captures Out/Zero and holds the result until consumed.
module alu_cmd_driver #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  alu_cmd_driver_if.master  bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e           state_q,     state_d;
  logic [3:0]       cnt_q,       cnt_d;
  logic [WIDTH-1:0] alu_a_q,     alu_a_d;
  logic [WIDTH-1:0] alu_b_q,     alu_b_d;
  logic [3:0]       alu_op_q,    alu_op_d;
  logic             alu_en_q,    alu_en_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic             res_zero_q,  res_zero_d;
  logic             res_err_q,   res_err_d;
  logic             busy_q,      busy_d;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_en_d    = 1'b0;
    cmd_ready_d = cmd_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_err_d   = res_err_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          alu_a_d     = bus.cmd_a;
          alu_b_d     = bus.cmd_b;
          alu_op_d    = bus.cmd_op;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (op_legal(bus.cmd_op)) begin
            state_d  = ISSUE;
            alu_en_d = 1'b1;
          end else begin
            // Illegal opcodes bypass the ALU and report straight away.
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_zero_d  = 1'b0;
            res_err_d   = 1'b1;
          end
        end
      end

      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end

      WAIT: begin
        if (cnt_q == 4'd0) begin
          res_data_d  = bus.alu_out;
          res_zero_d  = bus.alu_zero;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_en_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_en_q    <= alu_en_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_enable = alu_en_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_zero   = res_zero_q;
  assign bus.res_err    = res_err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed + randomized bench for alu_cmd_driver with LATENCY=1 and LATENCY=3
// instances, each driving a pipelined behavioural ALU that emits noise off-capture.
module tb_alu_cmd_driver;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst3_n;
  logic busy1, busy3;

  alu_cmd_driver_if #(.WIDTH(W)) if1 ();
  alu_cmd_driver_if #(.WIDTH(W)) if3 ();

  alu_cmd_driver #(.WIDTH(W), .LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(rst1_n), .bus(if1), .busy(busy1));
  alu_cmd_driver #(.WIDTH(W), .LATENCY(3)) u_dut3 (
    .clk(clk), .resetn(rst3_n), .bus(if3), .busy(busy3));

  int legal_ops [10] = '{0, 1, 2, 3, 4, 8, 9, 10, 12, 13};

  function automatic bit is_legal(input logic [3:0] op);
    is_legal = 1'b0;
    foreach (legal_ops[i]) if (int'(op) == legal_ops[i]) is_legal = 1'b1;
  endfunction

  // Returns {zero, result}.
  function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] op);
    logic [W-1:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = ~a;
      4'd8:    r = (a >> 1) | (a & 32'h8000_0000);
      4'd9:    r = a << 1;
      4'd10:   r = a >> 1;
      4'd12:   r = (a << 1) | (a >> 31);
      4'd13:   r = (a >> 1) | (a << 31);
      default: r = '0;
    endcase
    alu_ref = {(r == '0), r};
  endfunction

  function automatic logic [W:0] noise();
    noise = {1'($urandom), 32'($urandom)};
  endfunction

  logic [W:0] pipe1;
  logic [W:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1    <= if1.alu_enable ? alu_ref(if1.alu_a, if1.alu_b, if1.alu_op) : noise();
    pipe3[0] <= if3.alu_enable ? alu_ref(if3.alu_a, if3.alu_b, if3.alu_op) : noise();
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign if1.alu_out  = pipe1[W-1:0];
  assign if1.alu_zero = pipe1[W];
  assign if3.alu_out  = pipe3[2][W-1:0];
  assign if3.alu_zero = pipe3[2][W];

  int en_cnt1 = 0, en_cnt3 = 0;
  always @(posedge clk) begin
    if (if1.alu_enable === 1'b1) en_cnt1++;
    if (if3.alu_enable === 1'b1) en_cnt3++;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int issued1 = 0, issued3 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    logic [W:0] exp;
    bit         legal;
    legal = is_legal(op);
    exp   = legal ? alu_ref(a, b, op) : '0;
    if3.cmd_a = a; if3.cmd_b = b; if3.cmd_op = op; if3.cmd_valid = 1'b1;
    chk("op3_ready_before", 64'(if3.cmd_ready), 64'd1);
    tick();
    if3.cmd_valid = 1'b0;
    if (legal) issued3++;
    chk("op3_issue_enable", 64'(if3.alu_enable), 64'(legal));
    if (legal) begin
      for (int k = 1; k <= 3; k++) begin
        tick();
        chk("op3_wait_no_valid", 64'(if3.res_valid), 64'd0);
        chk("op3_wait_enable_low", 64'(if3.alu_enable), 64'd0);
      end
      tick();
    end
    chk("op3_res_valid", 64'(if3.res_valid), 64'd1);
    chk("op3_res_data", 64'(if3.res_data), 64'(exp[W-1:0]));
    chk("op3_res_zero", 64'(if3.res_zero), 64'(exp[W]));
    chk("op3_res_err", 64'(if3.res_err), 64'(!legal));
    chk("op3_alu_op_held", 64'(if3.alu_op), 64'(op));
    tick();
    chk("op3_done_valid_low", 64'(if3.res_valid), 64'd0);
    chk("op3_done_ready", 64'(if3.cmd_ready), 64'd1);
    chk("op3_done_busy", 64'(busy3), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    rst1_n = 1'b0; rst3_n = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd_a = '0; if1.cmd_b = '0; if1.cmd_op = '0; if1.res_ready = 1'b0;
    if3.cmd_valid = 1'b0; if3.cmd_a = '0; if3.cmd_b = '0; if3.cmd_op = '0; if3.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(if1.cmd_ready), 64'd1);
    chk("rst_res_valid", 64'(if1.res_valid), 64'd0);
    chk("rst_alu_enable", 64'(if1.alu_enable), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_res_data", 64'(if1.res_data), 64'd0);
    chk("rst_alu_a", 64'(if1.alu_a), 64'd0);
    chk("rst3_cmd_ready", 64'(if3.cmd_ready), 64'd1);
    @(negedge clk);
    rst1_n = 1'b1; rst3_n = 1'b1;
    tick();

    // Test 1: add with LATENCY=1
    if1.res_ready = 1'b1;
    if1.cmd_a = 32'h96F20BE5; if1.cmd_b = 32'hB4AC2923; if1.cmd_op = 4'd0; if1.cmd_valid = 1'b1;
    chk("t1_ready", 64'(if1.cmd_ready), 64'd1);
    tick(); issued1++;
    if1.cmd_valid = 1'b0;
    chk("t1_enable_hi", 64'(if1.alu_enable), 64'd1);
    chk("t1_ready_lo", 64'(if1.cmd_ready), 64'd0);
    chk("t1_busy", 64'(busy1), 64'd1);
    chk("t1_alu_a", 64'(if1.alu_a), 64'h96F20BE5);
    chk("t1_alu_b", 64'(if1.alu_b), 64'hB4AC2923);
    tick();
    chk("t1_enable_lo", 64'(if1.alu_enable), 64'd0);
    chk("t1_valid_early", 64'(if1.res_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(if1.res_valid), 64'd1);
    chk("t1_data", 64'(if1.res_data), 64'h4B9E3508);
    chk("t1_zero", 64'(if1.res_zero), 64'd0);
    chk("t1_err", 64'(if1.res_err), 64'd0);
    chk("t1_ready_done", 64'(if1.cmd_ready), 64'd0);
    tick();
    chk("t1_valid_drop", 64'(if1.res_valid), 64'd0);
    chk("t1_ready_back", 64'(if1.cmd_ready), 64'd1);
    chk("t1_busy_idle", 64'(busy1), 64'd0);

    // Test 2: AND then A-A back-to-back with cmd_valid held high
    if1.cmd_a = 32'h96F20BE5; if1.cmd_b = 32'hB4AC2923; if1.cmd_op = 4'd2; if1.cmd_valid = 1'b1;
    tick(); issued1++;
    if1.cmd_b = 32'h96F20BE5; if1.cmd_op = 4'd1;
    chk("t2_enable", 64'(if1.alu_enable), 64'd1);
    chk("t2_op_first", 64'(if1.alu_op), 64'd2);
    tick();
    chk("t2_b_stable", 64'(if1.alu_b), 64'hB4AC2923);
    chk("t2_op_stable", 64'(if1.alu_op), 64'd2);
    tick();
    chk("t2_and_valid", 64'(if1.res_valid), 64'd1);
    chk("t2_and_data", 64'(if1.res_data), 64'h94A00921);
    chk("t2_and_zero", 64'(if1.res_zero), 64'd0);
    chk("t2_b_stable2", 64'(if1.alu_b), 64'hB4AC2923);
    tick();
    chk("t2_ready_back", 64'(if1.cmd_ready), 64'd1);
    chk("t2_op_held_idle", 64'(if1.alu_op), 64'd2);
    tick(); issued1++;
    if1.cmd_valid = 1'b0;
    chk("t2_sub_enable", 64'(if1.alu_enable), 64'd1);
    chk("t2_sub_op", 64'(if1.alu_op), 64'd1);
    chk("t2_sub_b", 64'(if1.alu_b), 64'h96F20BE5);
    tick();
    tick();
    chk("t2_sub_valid", 64'(if1.res_valid), 64'd1);
    chk("t2_sub_data", 64'(if1.res_data), 64'h0);
    chk("t2_sub_zero", 64'(if1.res_zero), 64'd1);
    tick();
    chk("t2_sub_drop", 64'(if1.res_valid), 64'd0);

    // Test 3: illegal opcode then NOT A
    if1.cmd_a = 32'h12345678; if1.cmd_op = 4'hF; if1.cmd_valid = 1'b1;
    tick();
    if1.cmd_valid = 1'b0;
    chk("t3_no_enable", 64'(if1.alu_enable), 64'd0);
    chk("t3_valid", 64'(if1.res_valid), 64'd1);
    chk("t3_err", 64'(if1.res_err), 64'd1);
    chk("t3_data", 64'(if1.res_data), 64'd0);
    chk("t3_zero", 64'(if1.res_zero), 64'd0);
    chk("t3_busy", 64'(busy1), 64'd1);
    tick();
    chk("t3_drop", 64'(if1.res_valid), 64'd0);
    chk("t3_ready", 64'(if1.cmd_ready), 64'd1);
    chk("t3_enable_count", 64'(en_cnt1), 64'(issued1));
    if1.cmd_a = 32'h96F20BE5; if1.cmd_op = 4'd4; if1.cmd_valid = 1'b1;
    tick(); issued1++;
    if1.cmd_valid = 1'b0;
    tick();
    tick();
    chk("t3_not_valid", 64'(if1.res_valid), 64'd1);
    chk("t3_not_data", 64'(if1.res_data), 64'h690DF41A);
    chk("t3_not_err", 64'(if1.res_err), 64'd0);
    tick();

    // Test 4: result backpressure
    if1.res_ready = 1'b0;
    if1.cmd_a = 32'h12345678; if1.cmd_b = 32'h0F0F0000; if1.cmd_op = 4'd3; if1.cmd_valid = 1'b1;
    tick(); issued1++;
    if1.cmd_valid = 1'b0;
    tick();
    tick();
    chk("t4_valid", 64'(if1.res_valid), 64'd1);
    chk("t4_data", 64'(if1.res_data), 64'h1F3F5678);
    for (int i = 0; i < 5; i++) begin
      if1.cmd_valid = (i % 2 == 0) && (i != 4);
      if1.cmd_a = $urandom; if1.cmd_b = $urandom; if1.cmd_op = 4'd0;
      tick();
      chk("t4_hold_valid", 64'(if1.res_valid), 64'd1);
      chk("t4_hold_data", 64'(if1.res_data), 64'h1F3F5678);
      chk("t4_hold_zero", 64'(if1.res_zero), 64'd0);
      chk("t4_hold_ready", 64'(if1.cmd_ready), 64'd0);
      chk("t4_hold_alu_a", 64'(if1.alu_a), 64'h12345678);
    end
    if1.cmd_valid = 1'b0;
    if1.res_ready = 1'b1;
    tick();
    chk("t4_release_valid", 64'(if1.res_valid), 64'd0);
    chk("t4_release_ready", 64'(if1.cmd_ready), 64'd1);
    chk("t4_release_alu_a", 64'(if1.alu_a), 64'h12345678);
    chk("t4_enable_count", 64'(en_cnt1), 64'(issued1));

    // Test 5: reset in WAIT with LATENCY=3
    if3.res_ready = 1'b1;
    if3.cmd_a = 32'h96F20BE5; if3.cmd_b = 32'hB4AC2923; if3.cmd_op = 4'd0; if3.cmd_valid = 1'b1;
    tick(); issued3++;
    if3.cmd_valid = 1'b0;
    chk("t5_enable", 64'(if3.alu_enable), 64'd1);
    tick();
    tick();
    rst3_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(if3.res_valid), 64'd0);
    chk("t5_rst_enable", 64'(if3.alu_enable), 64'd0);
    chk("t5_rst_busy", 64'(busy3), 64'd0);
    chk("t5_rst_ready", 64'(if3.cmd_ready), 64'd1);
    chk("t5_rst_alu_a", 64'(if3.alu_a), 64'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_stale_valid", 64'(if3.res_valid), 64'd0);
      chk("t5_idle_busy", 64'(busy3), 64'd0);
    end
    do_op3(32'h96F20BE5, 32'hB4AC2923, 4'd0);
    chk("t5_fresh_data", 64'(if3.res_data), 64'h4B9E3508);

    // Test 6: all legal opcodes on random operands, plus edge operands
    foreach (legal_ops[i]) begin
      ra = $urandom; rb = $urandom;
      do_op3(ra, rb, 4'(legal_ops[i]));
    end
    ra = $urandom;
    do_op3(ra, ra, 4'd1);
    do_op3(32'h8000_0001, 32'h0, 4'd8);
    do_op3(32'h8000_0001, 32'h0, 4'd12);
    do_op3(32'h8000_0001, 32'h0, 4'd13);
    do_op3($urandom, $urandom, 4'd7);
    chk("t6_enable_count", 64'(en_cnt3), 64'(issued3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator side of the clocked ALU interface (A, B, Op, enable in; Out, Zero back).
- Accepts one operation at a time from a control unit over a valid/ready command channel.
- Screens the opcode, drives the ALU's operand/opcode/enable ports for exactly one issue cycle, waits the ALU latency, captures Out/Zero, and holds the result on a valid/ready result channel until it is consumed.

Parameters:
- WIDTH, 32: operand/result width.
- LATENCY, 1: clock edges from the ALU registering enable to Out/Zero being stable; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_op  in  4  opcode.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_op  out  4  to ALU Op.
- alu_enable  out  1  to ALU enable.
- alu_out  in  WIDTH  from ALU Out.
- alu_zero  in  1  from ALU Zero.
- res_valid  out  1  result present.
- res_ready  in  1  consumer takes result.
- res_data  out  WIDTH  captured result.
- res_zero  out  1  captured Zero flag.
- res_err  out  1  opcode was illegal.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (resetn low, async):
  - State goes to IDLE and the wait counter clears.
  - All outputs go to 0 except cmd_ready, which goes to 1.
  - Any in-flight operation or result is discarded.
  - Reset during any state is legal and takes effect immediately.
- Legal opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 not A, 1000 asr1, 1001 lsl1, 1010 lsr1, 1100 rol1, 1101 ror1. Every other code is illegal.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_op.
  - Legal opcode -> ISSUE.
  - Illegal opcode -> DONE with res_data=0, res_zero=0, res_err=1. No ISSUE or WAIT is entered, and alu_enable never rises.
- ISSUE:
  - Lasts exactly one cycle with alu_enable=1.
  - Loads the counter with LATENCY-1, then -> WAIT.
- WAIT:
  - alu_enable=0.
  - Counter decrements each cycle.
  - On the edge where the counter is 0, capture alu_out->res_data and alu_zero->res_zero, set res_err=0, then -> DONE.
- DONE:
  - res_valid=1; res_data, res_zero and res_err are held stable.
  - On res_valid&res_ready -> IDLE, and res_valid drops the next cycle.
- Timing: for an accept at edge E0, alu_enable is high between E0 and E1, capture happens at edge E(1+LATENCY), and res_valid is high from E(1+LATENCY). With LATENCY=1 this is two edges from accept.
- alu_a, alu_b and alu_op hold their values from accept until the next accept; they never change while busy.
- cmd_ready=0 in ISSUE, WAIT and DONE. There is no same-cycle bypass: after a DONE handshake, cmd_ready returns one cycle later, giving a minimum of LATENCY+3 cycles per operation.
- cmd_valid while not ready is ignored, and cmd_* may change freely while not ready.
- res_ready outside DONE has no effect.
- Handshake rule: once res_valid is asserted it stays asserted until consumed.
- Ignored edge cases:
  - alu_out/alu_zero changes outside the capture edge.
  - Assertion of cmd_valid in the same cycle that resetn deasserts; the first accept may occur on the following edge.

Test Plan:
1. Add, LATENCY=1, res_ready=1. Stimulus: cmd_a=0x96F20BE5, cmd_b=0xB4AC2923, op=0000. Required: alu_enable high for exactly 1 cycle; res_valid two edges after accept; res_data=0x4B9E3508, res_zero=0, res_err=0; cmd_ready back high one cycle after the handshake.
2. AND, then sub of A-A, back-to-back with cmd_valid held high. Required: res_data=0x94A00921 with res_zero=0, then res_data=0x00000000 with res_zero=1; alu_a/alu_b/alu_op stable through each operation.
3. Illegal opcode 1111. Required: alu_enable never asserted; res_valid one edge after accept with res_err=1, res_data=0, res_zero=0; the next legal op (0100 with A=0x96F20BE5) returns 0x690DF41A and res_err=0.
4. Backpressure: hold res_ready=0 for 5 cycles in DONE, and pulse cmd_valid with other operands. Required: res_valid/res_data/res_zero unchanged, cmd_ready=0, alu_a unchanged; completes on the first cycle res_ready=1.
5. Reset mid-WAIT: LATENCY=3, assert resetn=0 one cycle after ISSUE. Required: immediately res_valid=0, alu_enable=0, busy=0, cmd_ready=1; after release, a fresh add completes with the correct 0x4B9E3508 and no stale result.
6. LATENCY=3 sweep over all ten legal opcodes against a behavioural ALU model. Required: capture exactly 4 edges after each accept; every res_data/res_zero matches the model.
